// File: rtl/f_led_multi.sv
// Multi-channel LED indicator driver: per-channel off / fixed / continuous blink / counted burst
// with exact half-period timing and burst busy/completion reporting.
module f_led_multi #(
    parameter int unsigned N_LEDS   = 4,
    parameter int unsigned HALF_CYC = 50_000_000,
    parameter int unsigned CNT_W    = 26,
    parameter int unsigned PULSE_W  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2*N_LEDS-1:0]         modo,
    input  logic [PULSE_W*N_LEDS-1:0]   n_pulsos,
    output logic [N_LEDS-1:0]           led,
    output logic [N_LEDS-1:0]           fin,
    output logic [N_LEDS-1:0]           ocupado
);

    localparam logic [2:0] APAGADO = 3'd0;
    localparam logic [2:0] FIJO    = 3'd1;
    localparam logic [2:0] INTER   = 3'd2;
    localparam logic [2:0] RAFAGA  = 3'd3;
    localparam logic [2:0] FIN     = 3'd4;

    localparam logic [CNT_W-1:0]   LAST = CNT_W'(HALF_CYC - 1);
    localparam logic [PULSE_W-1:0] ONE  = PULSE_W'(1);

    for (genvar i = 0; i < int'(N_LEDS); i++) begin : g_ch
        logic [2:0]         state, state_nx;
        logic [CNT_W-1:0]   cnt, cnt_nx;
        logic [PULSE_W-1:0] restantes, restantes_nx;
        logic [1:0]         modo_q, modo_q_nx;
        logic               led_r, led_nx;
        logic               fin_r, fin_nx;
        logic               ocup_r, ocup_nx;
        logic [1:0]         modo_i;
        logic [PULSE_W-1:0] n_i;

        assign modo_i = modo[2*i +: 2];
        assign n_i    = n_pulsos[PULSE_W*i +: PULSE_W];

        // Next-state and output logic; a mode change always wins over ongoing activity
        always_comb begin
            state_nx     = state;
            cnt_nx       = cnt;
            restantes_nx = restantes;
            modo_q_nx    = modo_q;
            led_nx       = led_r;
            fin_nx       = 1'b0;
            ocup_nx      = ocup_r;

            if (modo_i != modo_q) begin
                modo_q_nx = modo_i;
                cnt_nx    = '0;
                case (modo_i)
                    2'b00: begin
                        state_nx = APAGADO;
                        led_nx   = 1'b0;
                        ocup_nx  = 1'b0;
                    end
                    2'b01: begin
                        state_nx = FIJO;
                        led_nx   = 1'b1;
                        ocup_nx  = 1'b0;
                    end
                    2'b10: begin
                        state_nx = INTER;
                        led_nx   = 1'b1;
                        ocup_nx  = 1'b0;
                    end
                    default: begin
                        if (n_i != '0) begin
                            state_nx     = RAFAGA;
                            led_nx       = 1'b1;
                            restantes_nx = n_i;
                            ocup_nx      = 1'b1;
                        end else begin
                            state_nx = FIN;
                            led_nx   = 1'b0;
                            ocup_nx  = 1'b0;
                            fin_nx   = 1'b1;
                        end
                    end
                endcase
            end else begin
                case (state)
                    APAGADO: begin
                        led_nx = 1'b0;
                        cnt_nx = '0;
                    end
                    FIJO: begin
                        led_nx = 1'b1;
                        cnt_nx = '0;
                    end
                    INTER: begin
                        if (cnt == LAST) begin
                            cnt_nx = '0;
                            led_nx = ~led_r;
                        end else begin
                            cnt_nx = cnt + CNT_W'(1);
                        end
                    end
                    RAFAGA: begin
                        if (cnt == LAST) begin
                            cnt_nx = '0;
                            if (led_r) begin
                                // Falling edge ends one pulse; the last one closes the burst
                                restantes_nx = restantes - ONE;
                                led_nx       = 1'b0;
                                if (restantes == ONE) begin
                                    ocup_nx  = 1'b0;
                                    fin_nx   = 1'b1;
                                    state_nx = FIN;
                                end
                            end else begin
                                led_nx = 1'b1;
                            end
                        end else begin
                            cnt_nx = cnt + CNT_W'(1);
                        end
                    end
                    FIN: begin
                        led_nx  = 1'b0;
                        ocup_nx = 1'b0;
                        cnt_nx  = '0;
                    end
                    default: begin
                        state_nx = APAGADO;
                        led_nx   = 1'b0;
                        ocup_nx  = 1'b0;
                        cnt_nx   = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state     <= APAGADO;
                cnt       <= '0;
                restantes <= '0;
                modo_q    <= 2'b00;
                led_r     <= 1'b0;
                fin_r     <= 1'b0;
                ocup_r    <= 1'b0;
            end else begin
                state     <= state_nx;
                cnt       <= cnt_nx;
                restantes <= restantes_nx;
                modo_q    <= modo_q_nx;
                led_r     <= led_nx;
                fin_r     <= fin_nx;
                ocup_r    <= ocup_nx;
            end
        end

        assign led[i]     = led_r;
        assign fin[i]     = fin_r;
        assign ocupado[i] = ocup_r;
    end

endmodule

// File: tb/tb_f_led_multi.sv
// Bench for f_led_multi: directed scenarios with literal expectations plus randomized
// mode/count stimulus checked every cycle against a closed-form timing model.
module tb_f_led_multi;

    localparam int N  = 4;
    localparam int H  = 4;
    localparam int PW = 4;

    logic           clk;
    logic           rst;
    logic [2*N-1:0] modo;
    logic [PW*N-1:0] n_pulsos;
    logic [N-1:0]   led, fin, ocupado;

    int n_checks = 0;
    int n_fail   = 0;

    f_led_multi #(
        .N_LEDS(N), .HALF_CYC(H), .CNT_W(26), .PULSE_W(PW)
    ) dut (
        .clk(clk), .rst(rst), .modo(modo), .n_pulsos(n_pulsos),
        .led(led), .fin(fin), .ocupado(ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: each channel remembers the edge of its last mode entry and the sampled count;
    // outputs follow from elapsed edges since entry.
    int cyc = 0;
    int mq[N];
    int ent[N];
    int np[N];
    logic [N-1:0] exp_led, exp_fin, exp_ocup;

    always @(posedge clk) begin
        cyc++;
        for (int ch = 0; ch < N; ch++) begin
            int d;
            int m;
            exp_led[ch]  = 1'b0;
            exp_fin[ch]  = 1'b0;
            exp_ocup[ch] = 1'b0;
            if (rst) begin
                mq[ch] = 0;
            end else begin
                m = int'(modo[2*ch +: 2]);
                if (m != mq[ch]) begin
                    mq[ch]  = m;
                    ent[ch] = cyc;
                    np[ch]  = int'(n_pulsos[PW*ch +: PW]);
                end
                d = cyc - ent[ch];
                case (mq[ch])
                    1: exp_led[ch] = 1'b1;
                    2: exp_led[ch] = ((d / H) % 2) == 0;
                    3: begin
                        if (np[ch] == 0) begin
                            exp_fin[ch] = (d == 0);
                        end else if (d < (2*np[ch] - 1) * H) begin
                            exp_led[ch]  = ((d / H) % 2) == 0;
                            exp_ocup[ch] = 1'b1;
                        end else if (d == (2*np[ch] - 1) * H) begin
                            exp_fin[ch] = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("model_led", 32'(led), 32'(exp_led));
        check("model_fin", 32'(fin), 32'(exp_fin));
        check("model_ocupado", 32'(ocupado), 32'(exp_ocup));
    end

    initial begin
        int falls;
        int fins;
        logic prev;

        rst      = 1'b1;
        modo     = 8'hFF;
        n_pulsos = 16'h1111;

        repeat (3) begin
            @(posedge clk); #1;
            check("rst_led", 32'(led), 32'h0);
            check("rst_fin", 32'(fin), 32'h0);
            check("rst_ocupado", 32'(ocupado), 32'h0);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("release_ocupado", 32'(ocupado), 32'hF);
        check("release_led", 32'(led), 32'hF);

        @(negedge clk); modo = 8'h00;
        repeat (3) @(negedge clk);

        // ch0 blink, ch1 burst of 3, ch2 zero-count burst, ch3 burst of 5 aborted later
        modo     = 8'b11_11_11_10;
        n_pulsos = 16'h5030;
        @(posedge clk); #1;
        for (int k = 0; k <= 85; k++) begin
            if (k >= 1)
                check("fin_pattern", 32'(fin), (k == 20) ? 32'h2 : 32'h0);
            case (k)
                0: begin
                    check("entry_fin", 32'(fin), 32'h4);
                    check("entry_ocupado", 32'(ocupado), 32'hA);
                    check("entry_led", 32'(led), 32'hB);
                end
                3:  check("k3_led01", 32'(led[1:0]), 32'h3);
                4:  check("k4_led01", 32'(led[1:0]), 32'h0);
                7: begin
                    check("abort_led3", 32'(led[3]), 32'h1);
                    check("abort_ocupado", 32'(ocupado), 32'h2);
                end
                8:  check("k8_led01", 32'(led[1:0]), 32'h3);
                12: check("k12_led1", 32'(led[1]), 32'h0);
                19: check("k19_ocupado1", 32'(ocupado[1]), 32'h1);
                20: begin
                    check("k20_led1", 32'(led[1]), 32'h0);
                    check("k20_ocupado1", 32'(ocupado[1]), 32'h0);
                end
                28: check("k28_led01", 32'(led[1:0]), 32'h0);
                80: check("k80_led0", 32'(led[0]), 32'h1);
                default: ;
            endcase
            @(negedge clk);
            if (k == 6) modo[7:6] = 2'b01;
            @(posedge clk); #1;
        end

        // Re-trigger ch1 with the maximum count; a later count change must be ignored
        @(negedge clk); modo[3:2] = 2'b00;
        @(negedge clk); modo[3:2] = 2'b11; n_pulsos[7:4] = 4'd15;
        falls = 0;
        fins  = 0;
        prev  = 1'b0;
        for (int i = 0; i < 140; i++) begin
            @(posedge clk); #1;
            if (prev && !led[1]) falls++;
            if (fin[1]) fins++;
            prev = led[1];
            if (i == 10) n_pulsos[7:4] = 4'd2;
        end
        check("max_burst_falls", 32'(falls), 32'd15);
        check("max_burst_fins", 32'(fins), 32'd1);

        // Randomized mode changes, counts and occasional reset
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 499) == 0);
            for (int ch = 0; ch < N; ch++) begin
                if ($urandom_range(0, 59) == 0)
                    modo[2*ch +: 2] = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 4) == 0)
                    n_pulsos[PW*ch +: PW] = 4'($urandom_range(0, 15));
            end
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
